// File: rtl/nbody_host_seq.sv
// rtl/nbody_host_seq.sv - bus master that loads bodies into the nbody accelerator and streams per-frame positions
`timescale 1ns/1ps
module nbody_host_seq #(
  parameter int BODIES          = 512,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int READ_LATENCY    = 1,
  parameter int POLL_INTERVAL   = 16,
  parameter int POLL_LIMIT      = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BODY_ADDR_WIDTH-1:0] cfg_num_bodies,
  input  logic [DATA_WIDTH-1:0]      cfg_gap,
  input  logic [15:0]                cfg_frames,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [DATA_WIDTH-1:0]      ld_data,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic                       m_write,
  output logic                       m_read,
  output logic                       m_chipselect,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  output logic                       pos_valid,
  input  logic                       pos_ready,
  output logic [DATA_WIDTH-1:0]      pos_x,
  output logic [DATA_WIDTH-1:0]      pos_y,
  output logic [BODY_ADDR_WIDTH-1:0] pos_body,
  output logic                       pos_last,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic                       err
);
  localparam int BF = ADDR_WIDTH - 7;
  localparam int WW = $clog2(POLL_INTERVAL + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int LW = $clog2(READ_LATENCY + 2);
  localparam logic [WW-1:0] WAIT_END = WW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] POLL_END = PW'(POLL_LIMIT - 1);
  localparam logic [LW-1:0] LAT_END  = LW'(READ_LATENCY);
  localparam logic [DATA_WIDTH-1:0] D_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BODY_ADDR_WIDTH-1:0] B_ONE = {{(BODY_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BODY_ADDR_WIDTH-1:0] B_ZERO = '0;

  localparam logic [6:0] OP_GO = 7'h00, OP_READ = 7'h01, OP_NBODIES = 7'h02, OP_WRITE_X = 7'h03;
  localparam logic [6:0] OP_GAP = 7'h08, OP_DONE = 7'h40, OP_READ_X = 7'h41, OP_READ_Y = 7'h42;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_GAP, S_LOAD, S_POLL_WAIT, S_POLL_RD,
    S_RB_X, S_RB_XW, S_RB_YW, S_RB_OUT, S_STOP_RD
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [6:0] op,
                                                   input logic [BODY_ADDR_WIDTH-1:0] body);
    logic [BF-1:0] b;
    b = '0;
    b[BODY_ADDR_WIDTH-1:0] = body;
    return {op, b};
  endfunction

  state_t                     r_state;
  logic [BODY_ADDR_WIDTH-1:0] r_n, r_idx;
  logic [DATA_WIDTH-1:0]      r_gap;
  logic [15:0]                r_frames, r_fc;
  logic [2:0]                 r_field;
  logic [WW-1:0]              r_wait;
  logic [PW-1:0]              r_polls;
  logic [LW-1:0]              r_lat;
  logic [ADDR_WIDTH-1:0]      r_m_addr;
  logic [DATA_WIDTH-1:0]      r_m_wdata, r_pos_x, r_pos_y;
  logic [BODY_ADDR_WIDTH-1:0] r_pos_body;
  logic r_m_write, r_m_read, r_ld_ready, r_pos_valid, r_pos_last, r_busy, r_err;

  // Load words bypass the registered bus path so each accepted word is written in its own cycle.
  logic                  w_ld_fire;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  assign w_ld_fire = r_ld_ready & ld_valid;
  assign w_ld_addr = f_addr(OP_WRITE_X + {4'b0, r_field}, r_idx);

  assign ld_ready     = r_ld_ready;
  assign m_write      = r_m_write | w_ld_fire;
  assign m_read       = r_m_read;
  assign m_chipselect = m_write | m_read;
  assign m_addr       = w_ld_fire ? w_ld_addr : r_m_addr;
  assign m_writedata  = w_ld_fire ? ld_data : r_m_wdata;
  assign pos_valid    = r_pos_valid;
  assign pos_x        = r_pos_x;
  assign pos_y        = r_pos_y;
  assign pos_body     = r_pos_body;
  assign pos_last     = r_pos_last;
  assign busy         = r_busy;
  assign frame_count  = r_fc;
  assign err          = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n <= '0; r_idx <= '0; r_gap <= '0; r_frames <= '0; r_fc <= '0;
      r_field <= '0; r_wait <= '0; r_polls <= '0; r_lat <= '0;
      r_m_addr <= '0; r_m_wdata <= '0; r_m_write <= 1'b0; r_m_read <= 1'b0;
      r_ld_ready <= 1'b0; r_pos_valid <= 1'b0; r_pos_x <= '0; r_pos_y <= '0;
      r_pos_body <= '0; r_pos_last <= 1'b0; r_busy <= 1'b0; r_err <= 1'b0;
    end else begin
      r_m_write <= 1'b0;
      r_m_read  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_n <= cfg_num_bodies; r_gap <= cfg_gap; r_frames <= cfg_frames; r_fc <= '0;
          if (cfg_num_bodies == B_ZERO || cfg_frames == 16'd0) begin
            r_err <= 1'b1;
          end else begin
            r_err <= 1'b0; r_busy <= 1'b1;
            r_m_write <= 1'b1; r_m_addr <= f_addr(OP_NBODIES, B_ZERO);
            r_m_wdata <= {{(DATA_WIDTH-BODY_ADDR_WIDTH){1'b0}}, cfg_num_bodies};
            r_state <= S_CFG_GAP;
          end
        end
        S_CFG_GAP: begin
          r_m_write <= 1'b1; r_m_addr <= f_addr(OP_GAP, B_ZERO); r_m_wdata <= r_gap;
          r_idx <= '0; r_field <= '0;
          r_state <= S_LOAD;
        end
        // First LOAD cycle carries the GAP write, so ld_ready opens one cycle later.
        S_LOAD: if (!r_ld_ready) begin
          r_ld_ready <= 1'b1;
        end else if (w_ld_fire) begin
          if (r_field == 3'd4) begin
            r_field <= '0;
            if (r_idx == r_n - B_ONE) begin
              r_ld_ready <= 1'b0;
              r_m_write <= 1'b1; r_m_addr <= f_addr(OP_GO, B_ZERO); r_m_wdata <= D_ONE;
              r_wait <= '0; r_polls <= '0;
              r_state <= S_POLL_WAIT;
            end else begin
              r_idx <= r_idx + B_ONE;
            end
          end else begin
            r_field <= r_field + 3'd1;
          end
        end
        S_POLL_WAIT: if (r_wait == WAIT_END) begin
          r_m_read <= 1'b1; r_m_addr <= f_addr(OP_DONE, B_ZERO);
          r_lat <= '0; r_state <= S_POLL_RD;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
        S_POLL_RD: if (r_lat == LAT_END) begin
          if (m_readdata[0]) begin
            r_m_write <= 1'b1; r_m_addr <= f_addr(OP_READ, B_ZERO); r_m_wdata <= D_ONE;
            r_idx <= '0; r_state <= S_RB_X;
          end else if (r_polls == POLL_END) begin
            r_err <= 1'b1;
            r_m_write <= 1'b1; r_m_addr <= f_addr(OP_GO, B_ZERO); r_m_wdata <= '0;
            r_state <= S_STOP_RD;
          end else begin
            r_polls <= r_polls + 1'b1; r_wait <= '0; r_state <= S_POLL_WAIT;
          end
        end else begin
          r_lat <= r_lat + 1'b1;
        end
        S_RB_X: begin
          r_m_read <= 1'b1; r_m_addr <= f_addr(OP_READ_X, r_idx);
          r_lat <= '0; r_state <= S_RB_XW;
        end
        S_RB_XW: if (r_lat == LAT_END) begin
          r_pos_x <= m_readdata;
          r_m_read <= 1'b1; r_m_addr <= f_addr(OP_READ_Y, r_idx);
          r_lat <= '0; r_state <= S_RB_YW;
        end else begin
          r_lat <= r_lat + 1'b1;
        end
        S_RB_YW: if (r_lat == LAT_END) begin
          r_pos_y <= m_readdata; r_pos_valid <= 1'b1;
          r_pos_body <= r_idx; r_pos_last <= (r_idx == r_n - B_ONE);
          r_state <= S_RB_OUT;
        end else begin
          r_lat <= r_lat + 1'b1;
        end
        S_RB_OUT: if (pos_ready) begin
          r_pos_valid <= 1'b0;
          r_m_write <= r_pos_last;
          r_m_read  <= ~r_pos_last;
          if (r_pos_last) begin
            r_fc <= r_fc + 16'd1;
            if (r_fc + 16'd1 < r_frames) begin
              r_m_addr <= f_addr(OP_READ, B_ZERO); r_m_wdata <= '0;
              r_wait <= '0; r_polls <= '0; r_state <= S_POLL_WAIT;
            end else begin
              r_m_addr <= f_addr(OP_GO, B_ZERO); r_m_wdata <= '0;
              r_state <= S_STOP_RD;
            end
          end else begin
            r_idx <= r_idx + B_ONE;
            r_m_addr <= f_addr(OP_READ_X, r_idx + B_ONE);
            r_lat <= '0; r_state <= S_RB_XW;
          end
        end
        S_STOP_RD: begin
          r_m_write <= 1'b1; r_m_addr <= f_addr(OP_READ, B_ZERO); r_m_wdata <= '0;
          r_busy <= 1'b0; r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nbody_host_seq.sv
// tb/tb_nbody_host_seq.sv - bench for nbody_host_seq with an accelerator model and bus/position scoreboards
`timescale 1ns/1ps
module tb_nbody_host_seq;
  localparam int PI = 4;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  cfg_num_bodies;
  logic [63:0] cfg_gap;
  logic [15:0] cfg_frames;
  logic        ld_valid, ld_ready;
  logic [63:0] ld_data;
  logic [15:0] m_addr;
  logic        m_write, m_read, m_chipselect;
  logic [63:0] m_writedata, m_readdata;
  logic        pos_valid, pos_ready, pos_last, busy, err;
  logic [63:0] pos_x, pos_y;
  logic [8:0]  pos_body;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  nbody_host_seq #(.POLL_INTERVAL(PI), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_bodies(cfg_num_bodies), .cfg_gap(cfg_gap),
    .cfg_frames(cfg_frames), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .m_addr(m_addr), .m_write(m_write), .m_read(m_read), .m_chipselect(m_chipselect),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y), .pos_body(pos_body),
    .pos_last(pos_last), .busy(busy), .frame_count(frame_count), .err(err));

  typedef struct packed { logic w; logic [15:0] a; logic [63:0] d; } bus_t;
  typedef struct { int n; int f; int da; logic [63:0] gap; bit fixed; bit stall; bit rnd;
                   bit exp_err; int exp_fc; } vec_t;

  bus_t        obs_q[$];
  bus_t        exp_q[$];
  logic [63:0] wq[$];
  logic [63:0] words[$];

  int checks_total = 0;
  int checks_pass  = 0;

  // Accelerator model state (written only by the monitor)
  int          poll_cnt = 0, pos_n = 0, pos_bad = 0, viol = 0;
  logic        pend_v = 1'b0;
  logic [63:0] pend_d = '0;
  logic [31:0] seed = '0;
  logic [8:0]  rb_idx = '0;
  // Written only by the main sequence
  int          mdl_da = 0;
  logic [8:0]  mdl_n = 9'd1;
  bit          hold_low = 1'b0, rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] fx(input logic [31:0] s, input logic [8:0] b);
    return {s, 16'hA5A5, 7'd0, b};
  endfunction
  function automatic logic [63:0] fy(input logic [31:0] s, input logic [8:0] b);
    return {~s, 16'h5A5A, 7'd0, b};
  endfunction
  function automatic logic [15:0] mk_addr(input int op, input int b);
    logic [6:0] o;
    logic [8:0] bb;
    o = op[6:0];
    bb = b[8:0];
    return {o, bb};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      poll_cnt <= 0; pend_v <= 1'b0; m_readdata <= '0;
    end else begin
      m_readdata <= pend_v ? pend_d : {$urandom, $urandom};
      pend_v <= m_read;
      if (m_read) begin
        obs_q.push_back({1'b0, m_addr, 64'd0});
        case (m_addr[15:9])
          7'h40: begin
            poll_cnt <= poll_cnt + 1;
            pend_d <= {$urandom, 31'($urandom), (mdl_da != 0 && poll_cnt + 1 == mdl_da)};
          end
          7'h41:   pend_d <= fx(seed, m_addr[8:0]);
          7'h42:   pend_d <= fy(seed, m_addr[8:0]);
          default: pend_d <= '0;
        endcase
      end
      if (m_write) begin
        obs_q.push_back({1'b1, m_addr, m_writedata});
        if (m_addr == 16'h0000 && m_writedata == 64'd1) poll_cnt <= 0;
        if (m_addr == 16'h0200) begin
          if (m_writedata == 64'd1) begin seed <= $urandom; rb_idx <= '0; end
          else poll_cnt <= 0;
        end
      end
      if ((m_write && m_read) || m_chipselect !== (m_write | m_read)) viol <= viol + 1;
      if (pos_valid && pos_ready) begin
        pos_n <= pos_n + 1;
        rb_idx <= rb_idx + 9'd1;
        if (pos_x !== fx(seed, rb_idx) || pos_y !== fy(seed, rb_idx) || pos_body !== rb_idx ||
            pos_last !== (rb_idx == mdl_n - 9'd1))
          pos_bad <= pos_bad + 1;
      end
    end
  end

  initial begin
    pos_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_low) pos_ready = 1'b0;
      else if (rdy_rand) pos_ready = ($urandom_range(0, 3) != 0);
      else pos_ready = 1'b1;
    end
  end

  initial begin
    bit acc;
    ld_valid = 1'b0; ld_data = '0;
    forever begin
      @(negedge clk); acc = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (acc && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin ld_valid = 1'b1; ld_data = wq[0]; end
      else begin ld_valid = 1'b0; ld_data = {$urandom, $urandom}; end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic w, input logic [15:0] a, input logic [63:0] d);
    exp_q.push_back({w, a, d});
  endtask

  task automatic load_words(input int n, input bit fixed);
    logic [63:0] w;
    words.delete(); wq.delete();
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 5; k++) begin
        w = fixed ? 64'(b * 5 + k + 1) : {$urandom, $urandom};
        words.push_back(w); wq.push_back(w);
      end
  endtask

  task automatic build_exp(input int n, input int f, input int da, input logic [63:0] gap);
    exp_q.delete();
    if (n != 0 && f != 0) begin
      push_exp(1'b1, 16'h0400, 64'(n));
      push_exp(1'b1, 16'h1000, gap);
      for (int b = 0; b < n; b++)
        for (int k = 0; k < 5; k++) push_exp(1'b1, mk_addr(3 + k, b), words[b * 5 + k]);
      push_exp(1'b1, 16'h0000, 64'd1);
      if (da == 0) begin
        for (int p = 0; p < PL; p++) push_exp(1'b0, 16'h8000, 64'd0);
      end else begin
        for (int fr = 0; fr < f; fr++) begin
          for (int p = 0; p < da; p++) push_exp(1'b0, 16'h8000, 64'd0);
          push_exp(1'b1, 16'h0200, 64'd1);
          for (int b = 0; b < n; b++) begin
            push_exp(1'b0, mk_addr(7'h41, b), 64'd0);
            push_exp(1'b0, mk_addr(7'h42, b), 64'd0);
          end
          if (fr < f - 1) push_exp(1'b1, 16'h0200, 64'd0);
        end
      end
      push_exp(1'b1, 16'h0000, 64'd0);
      push_exp(1'b1, 16'h0200, 64'd0);
    end
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int base, pbase, bbase, vbase, cyc, m, i, onum;
    logic [63:0] sx, sy;
    logic [8:0]  sb;
    logic        sl;
    bit          stable;
    mdl_da = v.da; mdl_n = v.n[8:0]; rdy_rand = v.rnd;
    load_words(v.n, v.fixed);
    base = obs_q.size(); pbase = pos_n; bbase = pos_bad; vbase = viol;
    if (v.stall) hold_low = 1'b1;
    cfg_num_bodies = v.n[8:0]; cfg_frames = v.f[15:0]; cfg_gap = v.gap;
    start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    if (busy) begin
      cfg_num_bodies = 9'($urandom); cfg_frames = 16'($urandom);
      start = 1'b1; tick(1); start = 1'b0;
    end
    if (v.stall) begin
      cyc = 0;
      while (!pos_valid && cyc < 2000) begin tick(1); cyc++; end
      chk({tag, "_stall_reach"}, pos_valid, 1'b1);
      sx = pos_x; sy = pos_y; sb = pos_body; sl = pos_last; onum = obs_q.size(); stable = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (!pos_valid || pos_x !== sx || pos_y !== sy || pos_body !== sb || pos_last !== sl)
          stable = 1'b0;
      end
      chk({tag, "_stall_hold"}, stable, 1'b1);
      chk({tag, "_stall_noread"}, obs_q.size(), onum);
      hold_low = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 20000) begin tick(1); cyc++; end
    chk({tag, "_finish"}, busy, 1'b0);
    tick(3);
    build_exp(v.n, v.f, v.da, v.gap);
    chk({tag, "_bus_len"}, obs_q.size() - base, exp_q.size());
    m = (obs_q.size() - base < exp_q.size()) ? obs_q.size() - base : exp_q.size();
    if (m > 0) begin
      i = 0;
      while (i < m - 1 && obs_q[base + i] === exp_q[i]) i++;
      chk({tag, "_bus_seq"}, obs_q[base + i], exp_q[i]);
    end
    chk({tag, "_err"}, err, v.exp_err);
    chk({tag, "_frames"}, frame_count, v.exp_fc[15:0]);
    chk({tag, "_pos_count"}, pos_n - pbase, (v.da == 0) ? 0 : v.n * v.f);
    chk({tag, "_pos_data"}, pos_bad - bbase, 0);
    chk({tag, "_strobe"}, viol - vbase, 0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    int base, cyc;
    tbl[0] = '{n:2, f:1, da:3, gap:64'd3, fixed:1, stall:0, rnd:0, exp_err:0, exp_fc:1};
    tbl[1] = '{n:2, f:1, da:3, gap:64'd3, fixed:1, stall:1, rnd:0, exp_err:0, exp_fc:1};
    tbl[2] = '{n:3, f:3, da:2, gap:64'h1234_5678_9abc_def0, fixed:0, stall:0, rnd:1, exp_err:0, exp_fc:3};
    tbl[3] = '{n:2, f:1, da:0, gap:64'd7, fixed:0, stall:0, rnd:1, exp_err:1, exp_fc:0};
    tbl[4] = '{n:0, f:1, da:1, gap:64'd9, fixed:0, stall:0, rnd:0, exp_err:1, exp_fc:0};
    tbl[5] = '{n:1, f:2, da:1, gap:64'd11, fixed:0, stall:0, rnd:1, exp_err:0, exp_fc:2};
    tbl[6] = '{n:4, f:0, da:1, gap:64'd13, fixed:0, stall:0, rnd:0, exp_err:1, exp_fc:0};

    rst = 1'b1; start = 1'b0; cfg_num_bodies = '0; cfg_gap = '0; cfg_frames = '0;
    tick(3);
    chk("rst_flags", {m_write, m_read, m_chipselect, ld_ready, pos_valid, pos_last, busy, err}, 0);
    chk("rst_bus", {m_addr, m_writedata}, 0);
    chk("rst_pos", {pos_x | pos_y, pos_body, frame_count}, 0);
    rst = 1'b0;
    tick(2);

    for (int t = 0; t < 7; t++) run_case(tbl[t], $sformatf("vec%0d", t));

    // Reset while bodies are still streaming in
    mdl_da = 2; mdl_n = 9'd3; rdy_rand = 1'b0;
    load_words(3, 1'b0);
    base = obs_q.size();
    cfg_num_bodies = 9'd3; cfg_frames = 16'd1; cfg_gap = 64'd5;
    start = 1'b1; tick(1); start = 1'b0;
    cyc = 0;
    while (obs_q.size() - base < 5 && cyc < 500) begin tick(1); cyc++; end
    chk("mid_reach_load", ld_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_flags", {m_write, m_read, m_chipselect, ld_ready, pos_valid, pos_last, busy, err}, 0);
    chk("mid_rst_bus", {m_addr, m_writedata, frame_count}, 0);
    tick(2);
    rst = 1'b0;
    wq.delete();
    tick(2);
    run_case(tbl[0], "after_rst");

    for (int r = 0; r < 4; r++) begin
      rv.n = $urandom_range(1, 6); rv.f = $urandom_range(1, 3); rv.da = $urandom_range(0, 4);
      rv.gap = {$urandom, $urandom}; rv.fixed = 0; rv.stall = 0; rv.rnd = 1;
      rv.exp_err = (rv.da == 0); rv.exp_fc = (rv.da == 0) ? 0 : rv.f;
      run_case(rv, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end
endmodule
